// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Defaults target a 100 MHz board clock divided down to 40 Hz.
package clk_div_pkg;

   localparam int CNT_W_DEFAULT    = 24;
   localparam int DEFAULT_DIV_100M = 1249999;

   typedef logic [CNT_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: 50%-duty divided clock, rising-edge tick, and a
// double-buffered divisor that only changes at the end of a full period.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int DEFAULT_DIV = DEFAULT_DIV_100M
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   output logic             clk_out,
   output logic             tick,
   output logic             pending
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_act_div;
   logic [CNT_W-1:0] r_pend_div;
   logic             r_pending;
   logic             r_clk_out;
   logic             r_tick;
   logic             w_terminal;
   logic             w_apply;

   assign w_terminal = (r_cnt == r_act_div);
   // Swap divisors only at end of high phase, or at once while the channel is idle.
   assign w_apply    = r_pending && (!enable || (w_terminal && r_clk_out));

   // Counter, output phase, tick and divisor buffering for this channel.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_cnt      <= {CNT_W{1'b0}};
         r_act_div  <= CNT_W'(DEFAULT_DIV);
         r_pend_div <= CNT_W'(DEFAULT_DIV);
         r_pending  <= 1'b0;
         r_clk_out  <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         if (w_apply) begin
            r_act_div <= r_pend_div;
         end else begin
            r_act_div <= r_act_div;
         end

         if (wr) begin
            r_pend_div <= wr_div;
            r_pending  <= 1'b1;
         end else if (w_apply) begin
            r_pending  <= 1'b0;
         end else begin
            r_pending  <= r_pending;
         end

         if (!enable) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
         end else if (w_terminal) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_clk_out <= ~r_clk_out;
            r_tick    <= ~r_clk_out;
         end else begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_clk_out <= r_clk_out;
            r_tick    <= 1'b0;
         end
      end
   end

   assign clk_out = r_clk_out;
   assign tick    = r_tick;
   assign pending = r_pending;

endmodule

// File: rtl/multi_clock_divider.sv
// N independent clock-enable dividers sharing one divisor write bus.
// Out-of-range channel indices on the bus match no channel and are dropped.
module multi_clock_divider
   import clk_div_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int DEFAULT_DIV = DEFAULT_DIV_100M,
   localparam int LCH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic [N_CH-1:0]  enable,
   input  logic             load,
   input  logic [LCH_W-1:0] load_ch,
   input  logic [CNT_W-1:0] load_div,
   output logic [N_CH-1:0]  clk_out,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  pending
);

   logic [N_CH-1:0] w_wr;

   genvar g;
   generate
      for (g = 0; g < N_CH; g++) begin : g_ch
         assign w_wr[g] = load && (load_ch == LCH_W'(g));

         clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
         ) u_ch (
            .clk_in  (clk_in),
            .reset   (reset),
            .enable  (enable[g]),
            .wr      (w_wr[g]),
            .wr_div  (load_div),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pending (pending[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider with DEFAULT_DIV=3 (period 8):
// a 4-channel instance plus a 3-channel instance for the unused-index write.
module tb_multi_clock_divider;

   logic       clk_in = 1'b0;
   logic       reset;
   logic [3:0] enable;
   logic       load;
   logic [1:0] load_ch;
   logic [7:0] load_div;
   logic [3:0] clk_out, tick, pending;

   logic [2:0] enable3;
   logic       load3;
   logic [1:0] load_ch3;
   logic [7:0] load_div3;
   logic [2:0] clk_out3, tick3, pending3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_in = ~clk_in;

   multi_clock_divider #(.N_CH(4), .CNT_W(8), .DEFAULT_DIV(3)) dut (
      .clk_in(clk_in), .reset(reset), .enable(enable), .load(load),
      .load_ch(load_ch), .load_div(load_div),
      .clk_out(clk_out), .tick(tick), .pending(pending)
   );

   multi_clock_divider #(.N_CH(3), .CNT_W(8), .DEFAULT_DIV(3)) dut3 (
      .clk_in(clk_in), .reset(reset), .enable(enable3), .load(load3),
      .load_ch(load_ch3), .load_div(load_div3),
      .clk_out(clk_out3), .tick(tick3), .pending(pending3)
   );

   // Expected waveform: first rise after edge `first`, phases of `half` cycles.
   function automatic logic pat_hi(int k, int first, int half);
      return (k >= first) && (((k - first) % (2 * half)) < half);
   endfunction

   function automatic logic pat_tk(int k, int first, int half);
      return (k >= first) && (((k - first) % (2 * half)) == 0);
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic start_run();
      reset = 1'b0; enable = 4'h0; enable3 = 3'h0;
      load = 1'b0; load3 = 1'b0;
      step();
      reset = 1'b1; enable = 4'hF; enable3 = 3'h7;
   endtask

   task automatic test_reset_release();
      logic [11:0] exp_v;
      reset = 1'b0; enable = 4'h0; enable3 = 3'h0;
      load = 1'b0; load_ch = 2'd0; load_div = 8'd0;
      load3 = 1'b0; load_ch3 = 2'd0; load_div3 = 8'd0;
      for (int k = 1; k <= 2; k++) begin
         step();
         n_tests++;
         if ({clk_out, tick, pending} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=000", k, {clk_out, tick, pending});
         end
      end
      reset = 1'b1; enable = 4'hF; enable3 = 3'h7;
      for (int k = 1; k <= 20; k++) begin
         step();
         exp_v = {{4{pat_hi(k, 4, 4)}}, {4{pat_tk(k, 4, 4)}}, 4'h0};
         n_tests++;
         if ({clk_out, tick, pending} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release k=%0d got=%h exp=%h", k, {clk_out, tick, pending}, exp_v);
         end
      end
   endtask

   task automatic test_glitch_free();
      logic [3:0] ec, et, ep;
      start_run();
      for (int k = 1; k <= 24; k++) begin
         step();
         for (int c = 0; c < 4; c++) begin
            if (c == 1 && k >= 8) begin
               ec[c] = pat_hi(k, 10, 2); et[c] = pat_tk(k, 10, 2);
            end else begin
               ec[c] = pat_hi(k, 4, 4);  et[c] = pat_tk(k, 4, 4);
            end
         end
         ep = (k == 6 || k == 7) ? 4'b0010 : 4'b0000;
         n_tests++;
         if ({clk_out, tick, pending} !== {ec, et, ep}) begin
            n_fail++;
            $display("FAIL glitch_free k=%0d got=%h exp=%h", k, {clk_out, tick, pending}, {ec, et, ep});
         end
         if (k == 5) begin
            load = 1'b1; load_ch = 2'd1; load_div = 8'd1;
         end
         if (k == 6) load = 1'b0;
      end
   endtask

   task automatic test_min_div();
      logic [3:0] ec, et, ep;
      start_run();
      load = 1'b1; load_ch = 2'd2; load_div = 8'd0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 1) load = 1'b0;
         for (int c = 0; c < 4; c++) begin
            if (c == 2 && k >= 8) begin
               ec[c] = pat_hi(k, 9, 1); et[c] = pat_tk(k, 9, 1);
            end else begin
               ec[c] = pat_hi(k, 4, 4); et[c] = pat_tk(k, 4, 4);
            end
         end
         ep = (k < 8) ? 4'b0100 : 4'b0000;
         n_tests++;
         if ({clk_out, tick, pending} !== {ec, et, ep}) begin
            n_fail++;
            $display("FAIL min_div k=%0d got=%h exp=%h", k, {clk_out, tick, pending}, {ec, et, ep});
         end
      end
   endtask

   task automatic test_enable_gating();
      logic [3:0] ec, et, ep;
      start_run();
      for (int k = 1; k <= 32; k++) begin
         step();
         for (int c = 0; c < 4; c++) begin
            if (c == 3 && k >= 6) begin
               ec[c] = pat_hi(k, 14, 6); et[c] = pat_tk(k, 14, 6);
            end else begin
               ec[c] = pat_hi(k, 4, 4);  et[c] = pat_tk(k, 4, 4);
            end
         end
         ep = (k == 5) ? 4'b1000 : 4'b0000;
         n_tests++;
         if ({clk_out, tick, pending} !== {ec, et, ep}) begin
            n_fail++;
            $display("FAIL enable_gating k=%0d got=%h exp=%h", k, {clk_out, tick, pending}, {ec, et, ep});
         end
         if (k == 4) begin
            load = 1'b1; load_ch = 2'd3; load_div = 8'd5;
         end
         if (k == 5) begin
            load = 1'b0; enable = 4'b0111;
         end
         if (k == 8) enable = 4'hF;
      end
   endtask

   task automatic test_write_corner();
      logic [8:0] exp_v;
      start_run();
      load3 = 1'b1; load_ch3 = 2'd3; load_div3 = 8'd0;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k == 1) load3 = 1'b0;
         exp_v = {{3{pat_hi(k, 4, 4)}}, {3{pat_tk(k, 4, 4)}}, 3'b000};
         n_tests++;
         if ({clk_out3, tick3, pending3} !== exp_v) begin
            n_fail++;
            $display("FAIL write_unused_ch k=%0d got=%h exp=%h", k, {clk_out3, tick3, pending3}, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ec, et, ep;
      start_run();
      load = 1'b1; load_ch = 2'd0; load_div = 8'd1;
      for (int k = 1; k <= 24; k++) begin
         step();
         if (k == 1) load = 1'b0;
         for (int c = 0; c < 4; c++) begin
            if (c == 0 && k >= 12) begin
               ec[c] = pat_hi(k, 15, 3); et[c] = pat_tk(k, 15, 3);
            end else if (c == 0 && k >= 8) begin
               ec[c] = pat_hi(k, 10, 2); et[c] = pat_tk(k, 10, 2);
            end else begin
               ec[c] = pat_hi(k, 4, 4);  et[c] = pat_tk(k, 4, 4);
            end
         end
         ep = (k < 12) ? 4'b0001 : 4'b0000;
         n_tests++;
         if ({clk_out, tick, pending} !== {ec, et, ep}) begin
            n_fail++;
            $display("FAIL write_at_boundary k=%0d got=%h exp=%h", k, {clk_out, tick, pending}, {ec, et, ep});
         end
         if (k == 7) begin
            load = 1'b1; load_ch = 2'd0; load_div = 8'd2;
         end
         if (k == 8) load = 1'b0;
      end
   endtask

   task automatic test_async_reset();
      logic [11:0] exp_v;
      start_run();
      load = 1'b1; load_ch = 2'd1; load_div = 8'd0;
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k == 1) load = 1'b0;
      end
      n_tests++;
      if ({clk_out, tick} !== 8'b0010_0010) begin
         n_fail++;
         $display("FAIL async_pre got=%h exp=22", {clk_out, tick});
      end
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if ({clk_out, tick, pending} !== 12'h000) begin
         n_fail++;
         $display("FAIL async_reset got=%h exp=000", {clk_out, tick, pending});
      end
      step();
      reset = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         exp_v = {{4{pat_hi(k, 4, 4)}}, {4{pat_tk(k, 4, 4)}}, 4'h0};
         n_tests++;
         if ({clk_out, tick, pending} !== exp_v) begin
            n_fail++;
            $display("FAIL async_release k=%0d got=%h exp=%h", k, {clk_out, tick, pending}, exp_v);
         end
      end
   endtask

   initial begin
      test_reset_release();
      test_glitch_free();
      test_min_div();
      test_enable_gating();
      test_write_corner();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
